// File: rtl/cfc_pkg.sv
// Shared definitions for the copy-free checkpoint (CFC) recovery controller.
// Holds the default configuration constants, the recovery FSM state encoding
// and pointer/count types sized for the default configuration.
package cfc_pkg;

  localparam int CFC_NUM_CKPT       = 8;
  localparam int CFC_TAG_W          = 5;
  localparam int CFC_RESTORE_CYCLES = 2;
  localparam int CFC_PTR_W          = $clog2(CFC_NUM_CKPT);
  localparam int CFC_CNT_W          = CFC_PTR_W + 1;

  typedef logic [CFC_PTR_W-1:0] cfcPtr_t;
  typedef logic [CFC_CNT_W-1:0] cfcCnt_t;
  typedef logic [CFC_TAG_W-1:0] cfcTag_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RESTORE = 2'd2
  } cfcState_t;

endpackage

// File: rtl/cfc_tag_fifo.sv
// Outstanding-branch tag FIFO mirroring the CFC checkpoint allocation order.
// Ports:
//   clk, reset       clock / asynchronous active-high reset
//   pushEn, pushTag  allocate a checkpoint for pushTag at head
//   commit, topPtr   ROB commit; releases the oldest entry when it matches
//   flushEn          search-and-rollback cycle for flushTag
//   releaseHit       oldest entry is released this cycle (combinational)
//   flushMiss        flushEn and no live entry matches (combinational)
//   full             count == NUM_CKPT
//   count            outstanding entries, 0..NUM_CKPT
module cfc_tag_fifo #(
  parameter int NUM_CKPT = 8,
  parameter int TAG_W    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pushEn,
  input  logic [TAG_W-1:0]            pushTag,
  input  logic                        commit,
  input  logic [TAG_W-1:0]            topPtr,
  input  logic                        flushEn,
  input  logic [TAG_W-1:0]            flushTag,
  output logic                        releaseHit,
  output logic                        flushMiss,
  output logic                        full,
  output logic [$clog2(NUM_CKPT):0]   count
);

  localparam int PTR_W = $clog2(NUM_CKPT);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [NUM_CKPT];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] tailEff, idx, matchOff;
  logic [CNT_W-1:0] countEff;
  logic             matchFound;

  assign releaseHit = commit && (count != '0) && (topPtr == mem[tail]);
  assign full       = (count == CNT_W'(NUM_CKPT));

  // A release in the flush cycle retires the oldest entry before the search,
  // so the search window starts at the post-release tail.
  assign tailEff  = tail + PTR_W'(releaseHit);
  assign countEff = count - CNT_W'(releaseHit);

  always_comb begin
    matchFound = 1'b0;
    matchOff   = '0;
    idx        = '0;
    for (int unsigned k = 0; k < NUM_CKPT; k++) begin
      idx = tailEff + PTR_W'(k);
      if (!matchFound && (CNT_W'(k) < countEff) && (mem[idx] == flushTag)) begin
        matchFound = 1'b1;
        matchOff   = PTR_W'(k);
      end
    end
  end

  assign flushMiss = flushEn && !matchFound;

  always_ff @(posedge clk) begin
    if (pushEn) mem[head] <= pushTag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail <= tailEff;
      if (flushEn) begin
        if (matchFound) begin
          head  <= tailEff + matchOff;
          count <= {1'b0, matchOff};
        end else begin
          count <= countEff;
        end
      end else begin
        if (pushEn) head <= head + 1'b1;
        count <= countEff + CNT_W'(pushEn);
      end
    end
  end

endmodule

// File: rtl/cfc_recovery_ctrl.sv
// CFC recovery controller: grants/stalls branch dispatch against checkpoint
// occupancy, mirrors the outstanding-branch tag FIFO and sequences
// misprediction recovery (flush strobes, then a settle window for the CFC
// BRAM read path during which dispatch is held).
// Ports:
//   clk, reset                               clock / async active-high reset
//   Dis_InstValid, Dis_BranchReq, Dis_BranchTag  dispatch branch request
//   Rob_Commit, Rob_TopPtr                   ROB commit of top entry
//   Cdb_Flush, Cdb_RobTag, Cdb_RobDepth      mispredict broadcast
//   Ctrl_BranchGrant, Ctrl_DisStall          dispatch handshake
//   Ctrl_CfcFlush, Ctrl_FrlRestore, Ctrl_RobRestore  one-cycle restore strobes
//   Ctrl_FlushTag, Ctrl_FlushDepth           latched flush branch
//   Ctrl_FlushMiss                           flush tag not outstanding
//   Ctrl_Recovering, Ctrl_BranchCount        status
module cfc_recovery_ctrl
  import cfc_pkg::*;
#(
  parameter int NUM_CKPT       = CFC_NUM_CKPT,
  parameter int TAG_W          = CFC_TAG_W,
  parameter int RESTORE_CYCLES = CFC_RESTORE_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Dis_InstValid,
  input  logic                       Dis_BranchReq,
  input  logic [TAG_W-1:0]           Dis_BranchTag,
  input  logic                       Rob_Commit,
  input  logic [TAG_W-1:0]           Rob_TopPtr,
  input  logic                       Cdb_Flush,
  input  logic [TAG_W-1:0]           Cdb_RobTag,
  input  logic [TAG_W-1:0]           Cdb_RobDepth,
  output logic                       Ctrl_BranchGrant,
  output logic                       Ctrl_DisStall,
  output logic                       Ctrl_CfcFlush,
  output logic                       Ctrl_FrlRestore,
  output logic                       Ctrl_RobRestore,
  output logic [TAG_W-1:0]           Ctrl_FlushTag,
  output logic [TAG_W-1:0]           Ctrl_FlushDepth,
  output logic                       Ctrl_FlushMiss,
  output logic                       Ctrl_Recovering,
  output logic [$clog2(NUM_CKPT):0]  Ctrl_BranchCount
);

  localparam int RC_W = (RESTORE_CYCLES < 1) ? 1 : $clog2(RESTORE_CYCLES + 1);

  cfcState_t        state, nextState;
  logic [RC_W-1:0]  restCnt;
  logic [TAG_W-1:0] flushTagQ, flushDepthQ;
  logic             latchFlush, nestedFlush, inFlush;
  logic             releaseHit, fifoMiss, fifoFull, branchReq;

  assign branchReq   = Dis_InstValid && Dis_BranchReq;
  assign inFlush     = (state == FLUSH);
  // Only an older branch (smaller depth from ROB top) can supersede the
  // recovery already in progress.
  assign nestedFlush = (state != IDLE) && Cdb_Flush && (Cdb_RobDepth < flushDepthQ);

  assign Ctrl_BranchGrant = (state == IDLE) && branchReq && !Cdb_Flush &&
                            (!fifoFull || releaseHit);
  assign Ctrl_DisStall    = (branchReq && !Ctrl_BranchGrant) || (state != IDLE) || Cdb_Flush;
  assign Ctrl_CfcFlush    = inFlush;
  assign Ctrl_FrlRestore  = inFlush;
  assign Ctrl_RobRestore  = inFlush;
  assign Ctrl_FlushMiss   = inFlush && fifoMiss;
  assign Ctrl_Recovering  = (state != IDLE);
  assign Ctrl_FlushTag    = flushTagQ;
  assign Ctrl_FlushDepth  = flushDepthQ;

  cfc_tag_fifo #(
    .NUM_CKPT (NUM_CKPT),
    .TAG_W    (TAG_W)
  ) u_tagFifo (
    .clk        (clk),
    .reset      (reset),
    .pushEn     (Ctrl_BranchGrant),
    .pushTag    (Dis_BranchTag),
    .commit     (Rob_Commit),
    .topPtr     (Rob_TopPtr),
    .flushEn    (inFlush),
    .flushTag   (flushTagQ),
    .releaseHit (releaseHit),
    .flushMiss  (fifoMiss),
    .full       (fifoFull),
    .count      (Ctrl_BranchCount)
  );

  always_comb begin
    nextState  = state;
    latchFlush = 1'b0;
    case (state)
      IDLE: begin
        if (Cdb_Flush) begin
          latchFlush = 1'b1;
          nextState  = FLUSH;
        end
      end
      FLUSH: begin
        if (nestedFlush) begin
          latchFlush = 1'b1;
          nextState  = FLUSH;
        end else begin
          nextState = RESTORE;
        end
      end
      RESTORE: begin
        if (nestedFlush) begin
          latchFlush = 1'b1;
          nextState  = FLUSH;
        end else if (restCnt <= RC_W'(1)) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      restCnt     <= '0;
      flushTagQ   <= '0;
      flushDepthQ <= '0;
    end else begin
      state <= nextState;
      if (state == FLUSH) begin
        restCnt <= RC_W'(RESTORE_CYCLES);
      end else if ((state == RESTORE) && (restCnt != '0)) begin
        restCnt <= restCnt - 1'b1;
      end
      if (latchFlush) begin
        flushTagQ   <= Cdb_RobTag;
        flushDepthQ <= Cdb_RobDepth;
      end
    end
  end

endmodule

// File: tb/tb_cfc_recovery_ctrl.sv
module tb_cfc_recovery_ctrl;
  import cfc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disValid = 1'b0, disReq = 1'b0;
  logic [4:0] disTag = '0;
  logic       robCommit = 1'b0;
  logic [4:0] robTop = '0;
  logic       cdbFlush = 1'b0;
  logic [4:0] cdbTag = '0, cdbDepth = '0;
  logic       grant, stall, cfcFlush, frlRestore, robRestore, flushMiss, recovering;
  logic [4:0] flushTag, flushDepth;
  logic [3:0] branchCount;

  int errors = 0;
  int checks = 0;

  cfc_recovery_ctrl #(
    .NUM_CKPT       (8),
    .TAG_W          (5),
    .RESTORE_CYCLES (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Dis_InstValid    (disValid),
    .Dis_BranchReq    (disReq),
    .Dis_BranchTag    (disTag),
    .Rob_Commit       (robCommit),
    .Rob_TopPtr       (robTop),
    .Cdb_Flush        (cdbFlush),
    .Cdb_RobTag       (cdbTag),
    .Cdb_RobDepth     (cdbDepth),
    .Ctrl_BranchGrant (grant),
    .Ctrl_DisStall    (stall),
    .Ctrl_CfcFlush    (cfcFlush),
    .Ctrl_FrlRestore  (frlRestore),
    .Ctrl_RobRestore  (robRestore),
    .Ctrl_FlushTag    (flushTag),
    .Ctrl_FlushDepth  (flushDepth),
    .Ctrl_FlushMiss   (flushMiss),
    .Ctrl_Recovering  (recovering),
    .Ctrl_BranchCount (branchCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v, rq, cm, fl;
    logic [4:0] tag, top, ftg, fdp;
    logic       eg, es, ef, em, er;
    logic [3:0] ec;
    logic [4:0] et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int v, int rq, int tag, int cm, int top,
                              int fl, int ftg, int fdp, int eg, int es, int ef,
                              int em, int er, int ec, int et);
    vec_t r;
    r.rst = 1'(rst); r.v = 1'(v); r.rq = 1'(rq); r.tag = 5'(tag);
    r.cm = 1'(cm); r.top = 5'(top); r.fl = 1'(fl); r.ftg = 5'(ftg);
    r.fdp = 5'(fdp); r.eg = 1'(eg); r.es = 1'(es); r.ef = 1'(ef);
    r.em = 1'(em); r.er = 1'(er); r.ec = 4'(ec); r.et = 5'(et);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(int v, int rq, int tag, int cm, int top, int fl, int ftg, int fdp);
    disValid = 1'(v); disReq = 1'(rq); disTag = 5'(tag);
    robCommit = 1'(cm); robTop = 5'(top);
    cdbFlush = 1'(fl); cdbTag = 5'(ftg); cdbDepth = 5'(fdp);
  endtask

  task automatic step(int v, int rq, int tag, int cm, int top, int fl, int ftg, int fdp);
    @(negedge clk);
    drive(v, rq, tag, cm, top, fl, ftg, fdp);
    #1;
  endtask

  initial begin
    // ---------------- vector table ----------------
    vecs.push_back(mk(1, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 0,0));
    // fill to full with tags 1..8
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1,1,i, 0,0, 0,0,0,  1,0,0,0,0, i-1,0));
    vecs.push_back(mk(0, 1,1,9, 0,0, 0,0,0,  0,1,0,0,0, 8,0));   // full, no commit
    vecs.push_back(mk(0, 1,1,9, 1,1, 0,0,0,  1,0,0,0,0, 8,0));   // full + release
    vecs.push_back(mk(0, 0,0,0, 1,2, 0,0,0,  0,0,0,0,0, 8,0));   // release only
    vecs.push_back(mk(0, 0,0,0, 1,5, 0,0,0,  0,0,0,0,0, 7,0));   // commit, tag mismatch
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 7,0));
    // flush hit: tags 3,5,9,12, flush 9 depth 6
    vecs.push_back(mk(1, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 0,0));
    vecs.push_back(mk(0, 1,1,3,  0,0, 0,0,0, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(0, 1,1,5,  0,0, 0,0,0, 1,0,0,0,0, 1,0));
    vecs.push_back(mk(0, 1,1,9,  0,0, 0,0,0, 1,0,0,0,0, 2,0));
    vecs.push_back(mk(0, 1,1,12, 0,0, 0,0,0, 1,0,0,0,0, 3,0));
    vecs.push_back(mk(0, 1,1,15, 0,0, 1,9,6, 0,1,0,0,0, 4,0));   // req blocked by flush
    vecs.push_back(mk(0, 0,0,0,  0,0, 0,0,0, 0,1,1,0,1, 4,9));   // FLUSH
    vecs.push_back(mk(0, 1,1,7,  0,0, 0,0,0, 0,1,0,0,1, 2,9));   // RESTORE, no grant
    vecs.push_back(mk(0, 0,0,0,  0,0, 0,0,0, 0,1,0,0,1, 2,9));
    vecs.push_back(mk(0, 1,1,7,  0,0, 0,0,0, 1,0,0,0,0, 2,9));   // dispatch resumes
    // flush miss: tag 20
    vecs.push_back(mk(0, 0,0,0, 0,0, 1,20,3, 0,1,0,0,0, 3,9));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,1,1,1, 3,20));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 3,20));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 3,20));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 3,20));
    // nested flush: tags 3,5,9,12,14
    vecs.push_back(mk(1, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 0,0));
    vecs.push_back(mk(0, 1,1,3,  0,0, 0,0,0, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(0, 1,1,5,  0,0, 0,0,0, 1,0,0,0,0, 1,0));
    vecs.push_back(mk(0, 1,1,9,  0,0, 0,0,0, 1,0,0,0,0, 2,0));
    vecs.push_back(mk(0, 1,1,12, 0,0, 0,0,0, 1,0,0,0,0, 3,0));
    vecs.push_back(mk(0, 1,1,14, 0,0, 0,0,0, 1,0,0,0,0, 4,0));
    vecs.push_back(mk(0, 0,0,0, 0,0, 1,12,6, 0,1,0,0,0, 5,0));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,1,0,1, 5,12));
    vecs.push_back(mk(0, 0,0,0, 0,0, 1,5,2,  0,1,0,0,1, 3,12));  // older: re-enter
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,1,0,1, 3,5));
    vecs.push_back(mk(0, 0,0,0, 0,0, 1,3,4,  0,1,0,0,1, 1,5));   // younger: ignored
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 1,5));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 1,5));
    // release of the flush target during FLUSH -> miss; then flush on empty
    vecs.push_back(mk(0, 0,0,0, 0,0, 1,3,1,  0,1,0,0,0, 1,5));
    vecs.push_back(mk(0, 0,0,0, 1,3, 0,0,0,  0,1,1,1,1, 1,3));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 0,3));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 0,3));
    vecs.push_back(mk(0, 0,0,0, 0,0, 1,4,1,  0,1,0,0,0, 0,3));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,1,1,1, 0,4));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 0,4));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,1,0,0,1, 0,4));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0,0,0,0,0, 0,4));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      drive(32'(vecs[i].v), 32'(vecs[i].rq), 32'(vecs[i].tag), 32'(vecs[i].cm),
            32'(vecs[i].top), 32'(vecs[i].fl), 32'(vecs[i].ftg), 32'(vecs[i].fdp));
      #1;
      chk($sformatf("v%0d grant", i),   32'(grant),       32'(vecs[i].eg));
      chk($sformatf("v%0d stall", i),   32'(stall),       32'(vecs[i].es));
      chk($sformatf("v%0d cfcFlush", i),32'(cfcFlush),    32'(vecs[i].ef));
      chk($sformatf("v%0d frl", i),     32'(frlRestore),  32'(vecs[i].ef));
      chk($sformatf("v%0d rob", i),     32'(robRestore),  32'(vecs[i].ef));
      chk($sformatf("v%0d miss", i),    32'(flushMiss),   32'(vecs[i].em));
      chk($sformatf("v%0d recov", i),   32'(recovering),  32'(vecs[i].er));
      chk($sformatf("v%0d count", i),   32'(branchCount), 32'(vecs[i].ec));
      chk($sformatf("v%0d flushTag", i),32'(flushTag),    32'(vecs[i].et));
    end

    // ---------------- async reset in the middle of RESTORE ----------------
    step(1,1,2, 0,0, 0,0,0);
    step(1,1,4, 0,0, 0,0,0);
    step(0,0,0, 0,0, 1,4,7);
    step(0,0,0, 0,0, 0,0,0);
    chk("mid flushDepth", 32'(flushDepth), 32'd7);
    chk("mid cfcFlush", 32'(cfcFlush), 32'd1);
    step(0,0,0, 0,0, 0,0,0);
    chk("mid restoring", 32'(recovering), 32'd1);
    chk("mid count", 32'(branchCount), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst recov", 32'(recovering), 32'd0);
    chk("rst count", 32'(branchCount), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst cfcFlush", 32'(cfcFlush), 32'd0);
    chk("rst flushTag", 32'(flushTag), 32'd0);
    chk("rst flushDepth", 32'(flushDepth), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-rst grant", 32'(grant), 32'd0);

    // ---------------- wrap-around then flush of physical index 1 ----------------
    for (int s = 0; s < 4; s++) begin
      step(1,1,s+1, 0,0, 0,0,0);
      chk($sformatf("wrap fill%0d grant", s), 32'(grant), 32'd1);
    end
    for (int n = 1; n <= 14; n++) begin
      step(1,1,n+4, 1,n, 0,0,0);
      chk($sformatf("wrap pair%0d grant", n), 32'(grant), 32'd1);
      chk($sformatf("wrap pair%0d count", n), 32'(branchCount), 32'd4);
    end
    step(0,0,0, 0,0, 1,18,3);
    step(0,0,0, 0,0, 0,0,0);
    chk("wrap flush strobe", 32'(cfcFlush), 32'd1);
    chk("wrap flush miss", 32'(flushMiss), 32'd0);
    step(0,0,0, 0,0, 0,0,0);
    chk("wrap count after flush", 32'(branchCount), 32'd3);
    step(0,0,0, 0,0, 0,0,0);
    step(1,1,25, 0,0, 0,0,0);
    chk("wrap regrant", 32'(grant), 32'd1);
    step(0,0,0, 1,15, 0,0,0);
    chk("wrap rel15 count", 32'(branchCount), 32'd4);
    step(0,0,0, 1,16, 0,0,0);
    chk("wrap rel16 count", 32'(branchCount), 32'd3);
    step(0,0,0, 1,17, 0,0,0);
    chk("wrap rel17 count", 32'(branchCount), 32'd2);
    step(0,0,0, 1,25, 0,0,0);
    chk("wrap rel25 count", 32'(branchCount), 32'd1);
    step(0,0,0, 0,0, 0,0,0);
    chk("wrap drained count", 32'(branchCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
